// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: operand width default,
// M-extension op codes as seen on the ALU op bus, and op decode helpers.
package div_unit_pkg;

  localparam int DIV_XLEN = 32;

  // Op codes shared with the ALU decode (5-bit alu_op bus).
  localparam logic [4:0] ALU_DIV  = 5'd12;
  localparam logic [4:0] ALU_DIVU = 5'd13;
  localparam logic [4:0] ALU_REM  = 5'd14;
  localparam logic [4:0] ALU_REMU = 5'd15;

  // Per-operation control captured at accept and used during sign fix-up.
  typedef struct packed {
    logic is_rem;  // return remainder instead of quotient
    logic neg_q;   // negate the magnitude quotient
    logic neg_r;   // negate the magnitude remainder (takes sign of dividend)
  } div_ctrl_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) ||
           (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One request in over valid/ready, one result out over valid/ready.
// Divide-by-zero and signed overflow are resolved at accept and skip
// the iteration; all other ops take XLEN cycles of CALC.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  quo;      // dividend shifting out MSB first, quotient shifting in
  logic [XLEN-1:0]  rem;      // partial remainder, always < divisor between steps
  logic [XLEN-1:0]  dvs;      // divisor magnitude
  div_ctrl_t        ctrl;
  logic [XLEN-1:0]  result_q;

  // Request-side decode
  logic            op_signed;
  logic            accept;
  logic            b_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_res;
  div_ctrl_t       ctrl_in;

  // Iteration datapath
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_sub;
  logic            step_ge;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] calc_res;
  logic            last_step;

  assign op_signed = is_signed_op(alu_op);

  // Flush has priority over a new accept; unknown ops are silently dropped.
  assign accept = req_valid && (state == S_IDLE) && !flush && is_div_op(alu_op);

  assign b_zero  = (b == '0);
  assign sgn_ovf = op_signed && (a == MIN_NEG) && (b == '1);
  assign special = b_zero || sgn_ovf;

  // Magnitudes; MIN_NEG negates to itself, which is its correct unsigned magnitude.
  assign a_mag = (op_signed && a[XLEN-1]) ? -a : a;
  assign b_mag = (op_signed && b[XLEN-1]) ? -b : b;

  assign ctrl_in.is_rem = is_rem_op(alu_op);
  assign ctrl_in.neg_q  = op_signed && (a[XLEN-1] ^ b[XLEN-1]);
  assign ctrl_in.neg_r  = op_signed && a[XLEN-1];

  // Results for the cases that bypass the iteration.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = ctrl_in.is_rem ? a : '1;
    end else if (sgn_ovf) begin
      special_res = ctrl_in.is_rem ? '0 : MIN_NEG;
    end
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The shifted remainder is XLEN+1 bits,
  // so the difference is negative exactly when its top bit is set.
  assign rem_shift = {rem, quo[XLEN-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs};
  assign step_ge   = !rem_sub[XLEN];
  assign rem_step  = step_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_step  = {quo[XLEN-2:0], step_ge};
  assign last_step = (count == LAST_CNT);

  // Sign fix applied to the final step's outputs on the way into DONE.
  assign quo_fix  = ctrl.neg_q ? -quo_step : quo_step;
  assign rem_fix  = ctrl.neg_r ? -rem_step : rem_step;
  assign calc_res = ctrl.is_rem ? rem_fix : quo_fix;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture at accept, one iteration per CALC cycle, result capture on entry to DONE.
  // NOTE: datapath registers are reset too, so result reads 0 after reset as the interface promises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      ctrl     <= '0;
      result_q <= '0;
    end else if (accept) begin
      count <= '0;
      quo   <= a_mag;
      rem   <= '0;
      dvs   <= b_mag;
      ctrl  <= ctrl_in;
      if (special) begin
        result_q <= special_res;
      end
    end else if ((state == S_CALC) && !flush) begin
      count <= count + CNT_W'(1);
      quo   <= quo_step;
      rem   <= rem_step;
      if (last_step) begin
        result_q <= calc_res;
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign result     = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, flush/reset
// behaviour, and randomized ops with random response stalls checked
// against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int XLEN   = 32;
  localparam int LAT_NORMAL = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      alu_op = 5'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] av,
                                            input logic [31:0] bv);
    bit sgn = (op == ALU_DIV) || (op == ALU_REM);
    bit rm  = (op == ALU_REM) || (op == ALU_REMU);
    int sa  = av;
    int sb  = bv;
    if (bv == 0) return rm ? av : 32'hFFFF_FFFF;
    if (sgn && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
    if (sgn) return rm ? 32'(sa % sb) : 32'(sa / sb);
    return rm ? (av % bv) : (av / bv);
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] av,
                                     input logic [31:0] bv);
    bit sgn = (op == ALU_DIV) || (op == ALU_REM);
    if (bv == 0) return 1;
    if (sgn && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 1;
    return LAT_NORMAL;
  endfunction

  // Issue one op starting on a negedge, check latency, result, stall hold
  // and the handshake afterwards. Returns on a negedge with the unit idle.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input int stall);
    int waitc = 0;
    int lat   = 0;
    logic [31:0] exp = ref_model(op, av, bv);
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "/ready_in"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    alu_op    = op;
    a         = av;
    b         = bv;
    resp_ready = 1'b0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        check({tag, "/busy_after_accept"}, {30'd0, busy, req_ready}, 32'b10);
      end
    end while (!resp_valid && lat < 100);
    check({tag, "/latency"}, 32'(lat), 32'(ref_latency(op, av, bv)));
    check({tag, "/result"}, result, exp);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "/hold_result"}, result, exp);
      check({tag, "/hold_flags"}, {30'd0, resp_valid, req_ready}, 32'b10);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/after_handshake"}, {29'd0, resp_valid, req_ready, busy}, 32'b010);
    last_exp = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [4:0] ops [4];
    int seen;
    ops[0] = ALU_DIV;
    ops[1] = ALU_DIVU;
    ops[2] = ALU_REM;
    ops[3] = ALU_REMU;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_flags", {29'd0, req_ready, resp_valid, busy}, 32'b100);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values
    do_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0);
    do_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 0);
    do_op("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'd2, 0);
    foreach (ops[i]) do_op("b_zero", ops[i], 32'h1234_5678, 32'h0, 1);
    do_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("divu_ovf_pattern", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 0);

    // Long response stall
    do_op("stall10", ALU_DIVU, 32'hDEAD_BEEF, 32'd1234, 10);

    // Flush in the fifth CALC cycle: no response, result untouched
    req_valid = 1'b1;
    alu_op = ALU_DIV;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_flags", {29'd0, req_ready, resp_valid, busy}, 32'b100);
    check("flush_result_kept", result, last_exp);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Flush beats an accept in IDLE; unknown op codes are ignored
    req_valid = 1'b1;
    alu_op = ALU_DIVU;
    a = 32'd9;
    b = 32'd3;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    alu_op = 5'd0;
    check("flush_blocks_accept", {30'd0, req_ready, busy}, 32'b10);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bad_op_ignored", {30'd0, req_ready, busy}, 32'b10);

    // Flush while holding a response in DONE
    do_op("pre_done_flush", ALU_REMU, 32'd55, 32'd10, 0);
    req_valid = 1'b1;
    alu_op = ALU_DIVU;
    a = 32'd77;
    b = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("done_before_flush", {31'd0, resp_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("done_flush_flags", {29'd0, req_ready, resp_valid, busy}, 32'b100);

    // Reset pulsed mid-CALC
    do_op("pre_reset", ALU_DIVU, 32'd500, 32'd3, 0);
    req_valid = 1'b1;
    alu_op = ALU_DIVU;
    a = 32'hFFFF_0000;
    b = 32'd17;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_reset_flags", {29'd0, req_ready, resp_valid, busy}, 32'b100);
    check("midop_reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after_reset", ALU_DIV, 32'hFFFF_FF00, 32'd16, 0);

    // Randomized ops with random divisor classes and random stalls
    foreach (ops[i]) begin
      for (int n = 0; n < 150; n++) begin
        logic [31:0] av = $urandom;
        logic [31:0] bv;
        case ($urandom_range(0, 3))
          0: bv = $urandom | 32'd1;
          1: bv = $urandom;
          2: bv = (n % 5 == 0) ? 32'd0 : 32'($urandom_range(1, 15));
          default: bv = $urandom >> $urandom_range(0, 31);
        endcase
        if (n % 37 == 0) begin
          av = 32'h8000_0000;
          bv = 32'hFFFF_FFFF;
        end
        do_op("random", ops[i], av, bv, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
